// File: rtl/fanin_level_qualifier.sv
// Stability filter on the fan-in combined level, with a valid/ready edge-event port and event/glitch counters.
// Build option: define FALL_EVT_EN to also report qualified falling edges as events.
module fanin_level_qualifier #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic             level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_rise,
    output logic             evt_overflow,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] evt_count,
    output logic [CNT_W-1:0] glitch_count
);

    localparam int QW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [QW-1:0] Q_ONE  = QW'(1);
    localparam logic [QW-1:0] Q_LAST = QW'(STABLE_CYCLES);
`ifdef FALL_EVT_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {LOW, RISE_Q, HIGH, FALL_Q} state_t;

    state_t         state, state_nxt;
    logic [QW-1:0]  qcnt, qcnt_nxt;
    logic           level_nxt;
    logic           rise_evt, fall_evt, glitch;
    logic           new_evt, can_load;

    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        level_nxt = level;
        rise_evt  = 1'b0;
        fall_evt  = 1'b0;
        glitch    = 1'b0;
        case (state)
            LOW: if (din) begin
                qcnt_nxt = Q_ONE;
                if (STABLE_CYCLES == 1) begin
                    state_nxt = HIGH;
                    level_nxt = 1'b1;
                    rise_evt  = 1'b1;
                end else begin
                    state_nxt = RISE_Q;
                end
            end
            RISE_Q: if (din) begin
                qcnt_nxt = qcnt + Q_ONE;
                if (qcnt_nxt == Q_LAST) begin
                    state_nxt = HIGH;
                    level_nxt = 1'b1;
                    rise_evt  = 1'b1;
                end
            end else begin
                state_nxt = LOW;
                glitch    = 1'b1;
            end
            HIGH: if (!din) begin
                qcnt_nxt = Q_ONE;
                if (STABLE_CYCLES == 1) begin
                    state_nxt = LOW;
                    level_nxt = 1'b0;
                    fall_evt  = FALL_EN;
                end else begin
                    state_nxt = FALL_Q;
                end
            end
            FALL_Q: if (!din) begin
                qcnt_nxt = qcnt + Q_ONE;
                if (qcnt_nxt == Q_LAST) begin
                    state_nxt = LOW;
                    level_nxt = 1'b0;
                    fall_evt  = FALL_EN;
                end
            end else begin
                state_nxt = HIGH;
                glitch    = 1'b1;
            end
            default: state_nxt = LOW;
        endcase
    end

    assign new_evt  = rise_evt | fall_evt;
    // A held event is replaced only when it is being accepted at this same edge.
    assign can_load = !evt_valid || evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOW;
            qcnt         <= '0;
            level        <= 1'b0;
            evt_valid    <= 1'b0;
            evt_rise     <= 1'b1;
            evt_overflow <= 1'b0;
            evt_count    <= '0;
            glitch_count <= '0;
        end else begin
            state <= state_nxt;
            qcnt  <= qcnt_nxt;
            level <= level_nxt;
            if (new_evt)
                evt_count <= evt_count + 1'b1;
            if (glitch && glitch_count != '1)
                glitch_count <= glitch_count + 1'b1;
            if (new_evt && can_load) begin
                evt_valid <= 1'b1;
                evt_rise  <= rise_evt;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (new_evt && !can_load)
                evt_overflow <= 1'b1;
            else if (clr_ovf)
                evt_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fanin_level_qualifier.sv
// Directed bench for fanin_level_qualifier (STABLE_CYCLES=4, CNT_W=8); expectations adapt to FALL_EVT_EN.
module tb_fanin_level_qualifier;

`ifdef FALL_EVT_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       level, evt_valid, evt_rise, evt_overflow;
    logic [7:0] evt_count, glitch_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    fanin_level_qualifier #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din(din), .level(level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_rise(evt_rise),
        .evt_overflow(evt_overflow), .clr_ovf(clr_ovf),
        .evt_count(evt_count), .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_valid"}, 32'(evt_valid), 0);
        chk({tag, "_rise"}, 32'(evt_rise), 1);
        chk({tag, "_ovf"}, 32'(evt_overflow), 0);
        chk({tag, "_evt_count"}, 32'(evt_count), 0);
        chk({tag, "_glitch_count"}, 32'(glitch_count), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout level=%0b evt_count=%0d", level, evt_count);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(2);
        chk_reset_vals("reset");
        rst = 1'b0;

        // 1: clean rise, then fall
        step(1);
        evt_ready = 1'b1;
        din = 1'b1;
        step(3);
        chk("t1_level_before", 32'(level), 0);
        chk("t1_valid_before", 32'(evt_valid), 0);
        step(1);
        exp_cnt = 1;
        chk("t1_level", 32'(level), 1);
        chk("t1_valid", 32'(evt_valid), 1);
        chk("t1_rise", 32'(evt_rise), 1);
        chk("t1_count", 32'(evt_count), 32'(exp_cnt));
        step(1);
        chk("t1_valid_drop", 32'(evt_valid), 0);
        step(5);
        chk("t1_level_hold", 32'(level), 1);
        chk("t1_glitch", 32'(glitch_count), 0);
        din = 1'b0;
        step(3);
        chk("t1_fall_level_before", 32'(level), 1);
        step(1);
        exp_cnt += FE;
        chk("t1_fall_level", 32'(level), 0);
        chk("t1_fall_valid", 32'(evt_valid), 32'(FE));
        chk("t1_fall_rise", 32'(evt_rise), 32'(1 - FE));
        chk("t1_fall_count", 32'(evt_count), 32'(exp_cnt));
        step(1);
        chk("t1_fall_valid_drop", 32'(evt_valid), 0);

        // 2: short pulses are rejected
        for (int p = 1; p <= 3; p++) begin
            din = 1'b1;
            step(p);
            din = 1'b0;
            step(5);
        end
        chk("t2_level", 32'(level), 0);
        chk("t2_valid", 32'(evt_valid), 0);
        chk("t2_glitch", 32'(glitch_count), 3);
        chk("t2_count", 32'(evt_count), 32'(exp_cnt));

        // 3: backpressure and overflow
        evt_ready = 1'b0;
        din = 1'b1;
        step(4);
        exp_cnt += 1;
        chk("t3_valid1", 32'(evt_valid), 1);
        chk("t3_rise1", 32'(evt_rise), 1);
        din = 1'b0;
        step(4);
        exp_cnt += FE;
        chk("t3_fall_level", 32'(level), 0);
        chk("t3_fall_ovf", 32'(evt_overflow), 32'(FE));
        chk("t3_fall_rise_held", 32'(evt_rise), 1);
        din = 1'b1;
        step(4);
        exp_cnt += 1;
        chk("t3_level2", 32'(level), 1);
        chk("t3_valid2", 32'(evt_valid), 1);
        chk("t3_rise2", 32'(evt_rise), 1);
        chk("t3_ovf", 32'(evt_overflow), 1);
        chk("t3_count", 32'(evt_count), 32'(exp_cnt));
        evt_ready = 1'b1;
        step(1);
        chk("t3_valid_accept", 32'(evt_valid), 0);
        chk("t3_ovf_sticky", 32'(evt_overflow), 1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", 32'(evt_overflow), 0);

        // 5: held event replaced at the edge it is accepted
        din = 1'b0;
        step(6);
        exp_cnt += FE;
        chk("t5_pre_valid", 32'(evt_valid), 0);
        evt_ready = 1'b0;
        din = 1'b1;
        step(4);
        exp_cnt += 1;
        chk("t5_held_valid", 32'(evt_valid), 1);
        din = 1'b0;
        step(4);
        exp_cnt += FE;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("t5_ovf_cleared", 32'(evt_overflow), 0);
        din = 1'b1;
        step(3);
        chk("t5_still_held", 32'(evt_valid), 1);
        evt_ready = 1'b1;
        step(1);
        exp_cnt += 1;
        chk("t5_valid", 32'(evt_valid), 1);
        chk("t5_rise", 32'(evt_rise), 1);
        chk("t5_ovf", 32'(evt_overflow), 0);
        chk("t5_count", 32'(evt_count), 32'(exp_cnt));
        step(1);
        chk("t5_valid_drop", 32'(evt_valid), 0);

        // 6: async reset mid-qualification with an event pending
        din = 1'b0;
        step(6);
        evt_ready = 1'b0;
        din = 1'b1;
        step(4);
        din = 1'b0;
        step(4);
        din = 1'b1;
        step(2);
        chk("t6_pending", 32'(evt_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("t6_async");
        step(1);
        #2 rst = 1'b0;
        evt_ready = 1'b1;
        step(3);
        chk("t6_fresh_level0", 32'(level), 0);
        chk("t6_no_evt_on_release", 32'(evt_valid), 0);
        step(1);
        chk("t6_fresh_level1", 32'(level), 1);
        chk("t6_count", 32'(evt_count), 1);

        // evt_count wrap after 256 rises (plus qualified falls when enabled)
        for (int i = 0; i < 255; i++) begin
            din = 1'b0;
            step(4);
            din = 1'b1;
            step(4);
        end
        exp_cnt = (1 + 255 + FE * 255) % 256;
        chk("wrap_count", 32'(evt_count), 32'(exp_cnt));
        chk("wrap_ovf", 32'(evt_overflow), 0);

        // glitch_count saturation
        for (int i = 0; i < 260; i++) begin
            din = 1'b0;
            step(1);
            din = 1'b1;
            step(1);
        end
        chk("sat_glitch", 32'(glitch_count), 255);
        chk("sat_level", 32'(level), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
